// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : MIPS-32 MEM-stage bridge to a word-wide synchronous data RAM.
//            Byte-addressed loads/stores, big-endian lanes, RMW sub-word
//            stores, optional misalignment trap (macro MEM_ALIGN_TRAP_EN).
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_op,
    input  logic [ADDR_WIDTH+1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rdata_valid,
    output logic                    misaligned,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_data,
    output logic                    ram_we,
    output logic                    ram_mr,
    input  logic [DATA_WIDTH-1:0]   ram_q
);

    localparam logic [2:0] c_op_lw  = 3'd0;
    localparam logic [2:0] c_op_lh  = 3'd1;
    localparam logic [2:0] c_op_lhu = 3'd2;
    localparam logic [2:0] c_op_lb  = 3'd3;
    localparam logic [2:0] c_op_lbu = 3'd4;
    localparam logic [2:0] c_op_sw  = 3'd5;
    localparam logic [2:0] c_op_sh  = 3'd6;
    localparam logic [2:0] c_op_sb  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_RESP = 3'd2,
        S_WR   = 3'd3
`ifdef MEM_ALIGN_TRAP_EN
        , S_ERR  = 3'd4
`endif
    } state_t;

    state_t                   state_q;
    logic [2:0]               op_q;
    logic [ADDR_WIDTH+1:0]    addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic                     rdata_valid_q;
    logic [DATA_WIDTH-1:0]    ram_data_q;

    logic [ADDR_WIDTH+1:0]    w_addr_eff;
    logic [DATA_WIDTH-1:0]    w_load;
    logic [DATA_WIDTH-1:0]    w_merge;

    // Big-endian lane select with sign/zero extension.
    function automatic logic [31:0] f_load(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (op)
            c_op_lh:  r = {{16{h[15]}}, h};
            c_op_lhu: r = {16'h0000, h};
            c_op_lb:  r = {{24{b[7]}}, b};
            c_op_lbu: r = {24'h000000, b};
            default:  r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] f_merge(input logic [2:0] op, input logic [1:0] off,
                                            input logic [31:0] w, input logic [31:0] wd);
        logic [31:0] m;
        m = w;
        if (op == c_op_sh) begin
            if (off[1]) m[15:0]  = wd[15:0];
            else        m[31:16] = wd[15:0];
        end else begin
            case (off)
                2'd0:    m[31:24] = wd[7:0];
                2'd1:    m[23:16] = wd[7:0];
                2'd2:    m[15:8]  = wd[7:0];
                default: m[7:0]   = wd[7:0];
            endcase
        end
        return m;
    endfunction

    always_comb begin
        w_addr_eff = req_addr;
`ifndef MEM_ALIGN_TRAP_EN
        // Without the trap, low bits are silently dropped so the access lands on a legal boundary.
        if (req_op == c_op_lw || req_op == c_op_sw) begin
            w_addr_eff[1:0] = 2'b00;
        end else if (req_op == c_op_lh || req_op == c_op_lhu || req_op == c_op_sh) begin
            w_addr_eff[0] = 1'b0;
        end
`endif
    end

`ifdef MEM_ALIGN_TRAP_EN
    logic w_misaligned;
    always_comb begin
        w_misaligned = 1'b0;
        if (req_op == c_op_lw || req_op == c_op_sw) begin
            w_misaligned = (req_addr[1:0] != 2'b00);
        end else if (req_op == c_op_lh || req_op == c_op_lhu || req_op == c_op_sh) begin
            w_misaligned = req_addr[0];
        end
    end
`endif

    assign w_load  = f_load(op_q, addr_q[1:0], ram_q);
    assign w_merge = f_merge(op_q, addr_q[1:0], ram_q, wdata_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            op_q          <= 3'd0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            ram_data_q    <= '0;
        end else begin
            rdata_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        addr_q  <= w_addr_eff;
                        wdata_q <= req_wdata;
`ifdef MEM_ALIGN_TRAP_EN
                        if (w_misaligned) begin
                            state_q <= S_ERR;
                        end else
`endif
                        if (req_op == c_op_sw) begin
                            ram_data_q <= req_wdata;
                            state_q    <= S_WR;
                        end else begin
                            state_q <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    if (op_q == c_op_sh || op_q == c_op_sb) begin
                        ram_data_q <= w_merge;
                        state_q    <= S_WR;
                    end else begin
                        rdata_q       <= w_load;
                        rdata_valid_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end
                end
                S_WR: begin
                    state_q <= S_IDLE;
                end
`ifdef MEM_ALIGN_TRAP_EN
                S_ERR: begin
                    state_q <= S_IDLE;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes are pure state decodes so an asynchronous reset kills a pending write at once.
    assign req_ready   = (state_q == S_IDLE);
    assign ram_we      = (state_q == S_WR);
    assign ram_mr      = (state_q == S_RD);
    assign ram_addr    = addr_q[ADDR_WIDTH+1:2];
    assign ram_data    = ram_data_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
`ifdef MEM_ALIGN_TRAP_EN
    assign misaligned  = (state_q == S_ERR);
`else
    assign misaligned  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed, table-driven bench for mem_access_unit with a
//            registered-address RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;
    localparam int NV = 21;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misaligned;
    logic [4:0]  ram_addr;
    logic [31:0] ram_data;
    logic        ram_we;
    logic        ram_mr;
    logic [31:0] ram_q;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata), .rdata_valid(rdata_valid), .misaligned(misaligned),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
        .ram_mr(ram_mr), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // RAM model: synchronous write, registered read address, plus a backdoor preload port.
    logic [31:0] mem [0:31];
    logic [4:0]  raddr_q = 5'd0;
    logic        bd_we = 1'b0;
    logic [4:0]  bd_addr = 5'd0;
    logic [31:0] bd_data = 32'd0;
    always @(posedge clk) begin
        if (ram_we)     mem[ram_addr] <= ram_data;
        else if (bd_we) mem[bd_addr]  <= bd_data;
        raddr_q <= ram_addr;
    end
    assign ram_q = mem[raddr_q];

    int ovl_cnt = 0;
    int mr_cnt  = 0;
    int mis_cnt = 0;
    always @(negedge clk) if (ram_we && ram_mr) ovl_cnt++;
    always @(posedge clk) begin
        if (ram_mr)     mr_cnt++;
        if (misaligned) mis_cnt++;
    end

    typedef struct {
        logic [2:0]  op;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          busy;
    } vec_t;
    vec_t vecs [NV];

    typedef struct {
        logic [2:0]  op;
        logic [6:0]  addr;
        logic [31:0] wd;
    } req_t;
    req_t b2b [3];

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_rd = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bd_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [6:0] addr, input logic [31:0] wd);
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("ready_timeout", 32'(k), 32'd0);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  busy;
        int  vat;
        bit  done;
        busy = 0; vat = 0; done = 1'b0;
        issue(v.op, v.addr, v.wdata);
        for (int i = 1; i <= 8 && !done; i++) begin
            @(negedge clk);
            if (rdata_valid && vat == 0) vat = i;
            if (req_ready) done = 1'b1;
            else           busy++;
        end
        chk($sformatf("v%0d_busy", idx), 32'(busy), 32'(v.busy));
        if (v.op < OP_SW) begin
            chk($sformatf("v%0d_latency", idx), 32'(vat), 32'd3);
            chk($sformatf("v%0d_rdata", idx), rdata, v.exp);
            last_rd = v.exp;
        end else begin
            chk($sformatf("v%0d_no_rvalid", idx), 32'(vat), 32'd0);
            chk($sformatf("v%0d_rdata_hold", idx), rdata, last_rd);
            chk($sformatf("v%0d_ramword", idx), mem[v.addr[6:2]], v.exp);
        end
    endtask

    initial begin
        int k;
        int acc;
        int cyc;
        int acc_cyc [3];

        vecs[0]  = '{OP_SW,  7'h08, 32'hDEADBEEF, 32'hDEADBEEF, 1};
        vecs[1]  = '{OP_LW,  7'h08, 32'h0,        32'hDEADBEEF, 2};
        vecs[2]  = '{OP_SW,  7'h08, 32'h11223344, 32'h11223344, 1};
        vecs[3]  = '{OP_SB,  7'h09, 32'h000000AA, 32'h11AA3344, 3};
        vecs[4]  = '{OP_LB,  7'h09, 32'h0,        32'hFFFFFFAA, 2};
        vecs[5]  = '{OP_LBU, 7'h09, 32'h0,        32'h000000AA, 2};
        vecs[6]  = '{OP_LBU, 7'h08, 32'h0,        32'h00000011, 2};
        vecs[7]  = '{OP_SW,  7'h0C, 32'h11223344, 32'h11223344, 1};
        vecs[8]  = '{OP_SH,  7'h0E, 32'h00008001, 32'h11228001, 3};
        vecs[9]  = '{OP_LH,  7'h0E, 32'h0,        32'hFFFF8001, 2};
        vecs[10] = '{OP_LHU, 7'h0C, 32'h0,        32'h00001122, 2};
        vecs[11] = '{OP_LB,  7'h0E, 32'h0,        32'hFFFFFF80, 2};
        vecs[12] = '{OP_LB,  7'h0F, 32'h0,        32'h00000001, 2};
        vecs[13] = '{OP_SB,  7'h0C, 32'hFFFFFF7F, 32'h7F228001, 3};
        vecs[14] = '{OP_LW,  7'h0C, 32'h0,        32'h7F228001, 2};
        vecs[15] = '{OP_LH,  7'h0C, 32'h0,        32'h00007F22, 2};
        vecs[16] = '{OP_SH,  7'h10, 32'h1234ABCD, 32'hABCD0000, 3};
        vecs[17] = '{OP_LB,  7'h11, 32'h0,        32'hFFFFFFCD, 2};
        vecs[18] = '{OP_LHU, 7'h12, 32'h0,        32'h00000000, 2};
        vecs[19] = '{OP_SB,  7'h13, 32'h00000099, 32'hABCD0099, 3};
        vecs[20] = '{OP_LHU, 7'h12, 32'h0,        32'h00000099, 2};

        b2b[0] = '{OP_SW, 7'h18, 32'hA5A5A5A5};
        b2b[1] = '{OP_SB, 7'h1B, 32'h0000003C};
        b2b[2] = '{OP_LW, 7'h18, 32'h0};

        rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 7'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_flags", {27'd0, req_ready, rdata_valid, misaligned, ram_we, ram_mr}, 32'h10);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_ram_bus", {27'd0, ram_addr} | ram_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        bd_write(5'd4, 32'h00000000);
        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

`ifdef MEM_ALIGN_TRAP_EN
        begin
            int mr0;
            mr0 = mr_cnt;
            issue(OP_LW, 7'h0A, 32'h0);
            @(negedge clk);
            chk("mis_pulse", {31'd0, misaligned}, 32'd1);
            chk("mis_busy", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
            chk("mis_one_cycle", {31'd0, misaligned}, 32'd0);
            chk("mis_ready", {31'd0, req_ready}, 32'd1);
            @(negedge clk);
            chk("mis_no_rvalid", {31'd0, rdata_valid}, 32'd0);
            chk("mis_no_ram_mr", 32'(mr_cnt), 32'(mr0));
            chk("mis_rdata_hold", rdata, last_rd);
        end
`else
        run_vec('{OP_LW,  7'h0A, 32'h0,        32'h11AA3344, 2}, 100);
        run_vec('{OP_LH,  7'h0B, 32'h0,        32'h00003344, 2}, 101);
        run_vec('{OP_SW,  7'h07, 32'h01020304, 32'h01020304, 1}, 102);
        run_vec('{OP_LW,  7'h04, 32'h0,        32'h01020304, 2}, 103);
        chk("no_misaligned", 32'(mis_cnt), 32'd0);
`endif

        // Back-to-back: req_valid stays high; request advances only after an accepting edge.
        for (int i = 0; i < 3; i++) acc_cyc[i] = -1;
        @(negedge clk);
        req_op = b2b[0].op; req_addr = b2b[0].addr; req_wdata = b2b[0].wd; req_valid = 1'b1;
        acc = 0; cyc = 0;
        while (acc < 3 && cyc < 40) begin
            if (req_ready) begin
                acc_cyc[acc] = cyc;
                acc++;
            end
            @(posedge clk); #1;
            if (acc < 3) begin
                req_op = b2b[acc].op; req_addr = b2b[acc].addr; req_wdata = b2b[acc].wd;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("b2b_accepts", 32'(acc), 32'd3);
        chk("b2b_acc0", 32'(acc_cyc[0]), 32'd0);
        chk("b2b_acc1", 32'(acc_cyc[1]), 32'd2);
        chk("b2b_acc2", 32'(acc_cyc[2]), 32'd6);
        k = 0;
        while (!rdata_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_rvalid_seen", {31'd0, rdata_valid}, 32'd1);
        chk("b2b_rdata", rdata, 32'hA5A5A53C);
        chk("b2b_ramword", mem[6], 32'hA5A5A53C);

        // Asynchronous reset while an SB sits in its write cycle.
        bd_write(5'd5, 32'hCAFEF00D);
        issue(OP_SB, 7'h14, 32'h00000055);
        k = 0;
        while (!ram_we && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("rst_reached_wr", {31'd0, ram_we}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_we_drop", {31'd0, ram_we}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_word_kept", mem[5], 32'hCAFEF00D);
        chk("rst_flags", {27'd0, req_ready, rdata_valid, misaligned, ram_we, ram_mr}, 32'h10);
        chk("rst_outputs", rdata | ram_data | {27'd0, ram_addr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_rd = 32'd0;
        run_vec('{OP_LW, 7'h14, 32'h0, 32'hCAFEF00D, 2}, 200);

        chk("we_mr_overlap", 32'(ovl_cnt), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the MEM-stage control of the MIPS-32 datapath and the word-wide data memory RAM. That RAM has one-cycle registered-address read latency and a synchronous write.
- Turns byte-addressed LW/LH/LHU/LB/LBU/SW/SH/SB requests into word accesses. Sub-word stores are done as read-modify-write.
- Formats load data: lane select plus sign/zero extension. Flags misaligned accesses.

Parameters:
- DATA_WIDTH, 32, data word width; fixed at 32 for MIPS.
- ADDR_WIDTH, 5, RAM word-address width. Byte address width is ADDR_WIDTH+2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request strobe; sampled only while req_ready=1
- req_ready  out  1  high only in IDLE
- req_op  in  3  0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB
- req_addr  in  ADDR_WIDTH+2  byte address
- req_wdata  in  32  store data; SH uses [15:0], SB uses [7:0]
- rdata  out  32  formatted load result
- rdata_valid  out  1  one-cycle pulse when rdata is new
- misaligned  out  1  one-cycle pulse on misaligned request
- ram_addr  out  ADDR_WIDTH  word address = latched req_addr[ADDR_WIDTH+1:2]
- ram_data  out  32  write data to RAM
- ram_we  out  1  RAM write enable
- ram_mr  out  1  RAM read strobe
- ram_q  in  32  RAM read data, valid the cycle after ram_addr is presented

Behaviour:
- Reset: state=IDLE. req_ready=1. rdata=0, rdata_valid=0, misaligned=0. ram_we=0, ram_mr=0, ram_addr=0, ram_data=0.
- Reset mid-operation aborts immediately. ram_we drops asynchronously (state-decoded), so a pending RMW write is lost. No response is issued.
- Handshake: request accepted on a rising edge with req_valid & req_ready. op, addr and wdata are latched. req_valid while busy is ignored; the requester holds the request.
- Alignment: LW/SW need addr[1:0]=00. LH/LHU/SH need addr[0]=0. Bytes are always aligned.
- Misaligned request: accepted, misaligned pulses in the next cycle (state ERR), no RAM access, return to IDLE.
- Byte order is big-endian. Offset 0 maps to bits [31:24], offset 3 to [7:0]. Halfword offset 0 maps to [31:16].
- FSM states: IDLE, RD, RESP, WR, ERR.
  - IDLE: wait for accept. Loads, SH and SB go to RD. SW goes to WR. Misaligned goes to ERR.
  - RD: ram_addr valid, ram_mr=1. RAM registers the address at the end of this cycle. Next state RESP.
  - RESP: ram_q valid.
    - Loads: rdata registered from the selected lane, sign-extended (LH/LB) or zero-extended (LHU/LBU). rdata_valid pulses in the following cycle. Back to IDLE.
    - SH/SB: the merged word (ram_q with the target lane replaced) is registered into ram_data. Next state WR.
  - WR: ram_we=1, ram_data = full req_wdata for SW or the merged word otherwise. Write commits at the end of the cycle. Next state IDLE.
  - ERR: misaligned=1 for one cycle. Next state IDLE.
- Latency from accept edge:
  - loads: rdata_valid high 3 cycles later (cycle after RESP)
  - SW: 1 busy cycle
  - SH/SB: 3 busy cycles
  - misaligned: 1 busy cycle
- rdata holds its value until the next load response. It is unchanged by stores or errors.
- ram_we and ram_mr are never both high.
- No write buffering: a load after a store always sees the committed data, because the store finishes before req_ready rises again.

Optional Feature:
- Macro: MEM_ALIGN_TRAP_EN.
- Defined: misaligned requests are detected and suppressed via ERR as above.
- Undefined: the ERR state is removed and misaligned is tied to 0. Low address bits are force-aligned before use: LW/SW clear [1:0], halfword ops clear [0]. The access then proceeds normally.

Test Plan:
- Reset: assert rst mid-SB during WR → ram_we drops the same cycle; RAM word unchanged; req_ready=1; all outputs 0.
- SW addr=0x08 wdata=0xDEADBEEF, then LW 0x08 → RAM word 2 = 0xDEADBEEF; rdata=0xDEADBEEF with rdata_valid pulse 3 cycles after the LW accept.
- SB 0x09 wdata=0x000000AA over word 0x11223344 → word becomes 0x11AA3344. LB 0x09 → 0xFFFFFFAA. LBU 0x09 → 0x000000AA.
- SH 0x0E wdata=0x8001 over word 0x11223344 at word 3 → 0x11228001. LH 0x0E → 0xFFFF8001. LHU 0x0C → 0x00001122.
- With MEM_ALIGN_TRAP_EN: LW 0x0A → misaligned pulse, no ram_mr, no rdata_valid. Without it: LW 0x0A reads word 2.
- Back-to-back: req_valid held high across three requests → each accepted only when req_ready=1; ram_we/ram_mr never overlap.
